// File: rtl/iterlm_pkg.sv
// rtl/iterlm_pkg.sv - shared types and constants for the IterLM sequential datapaths
package iterlm_pkg;

   localparam int DIV_W    = 16;
   localparam int DIV_ITER = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/cla_sub_17.sv
// rtl/cla_sub_17.sv - 17-bit subtractor a - b from 4-bit lookahead groups plus a top bit
module cla_sub_17 (
   input  logic [16:0] a,
   input  logic [16:0] b,
   output logic [16:0] diff
);

   logic [16:0] bn;
   logic [16:0] p;
   logic [15:0] g;
   logic [15:0] c;
   logic [4:0]  gc;
   logic [3:0]  grp_g;
   logic [3:0]  grp_p;

   assign bn = ~b;
   assign p  = a ^ bn;
   assign g  = a[15:0] & bn[15:0];

   // Carry-in of 1 on the inverted operand completes the two's complement.
   always_comb begin
      gc    = '0;
      c     = '0;
      grp_g = '0;
      grp_p = '0;
      gc[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
         grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
         gc[k+1]  = grp_g[k] | (grp_p[k] & gc[k]);
      end
   end

   assign diff[15:0] = p[15:0] ^ c;
   assign diff[16]   = p[16] ^ gc[4];

endmodule

// File: rtl/iterlm_div_16.sv
// rtl/iterlm_div_16.sv - sequential 16-bit unsigned restoring divider, one quotient bit per cycle
import iterlm_pkg::*;

module iterlm_div_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(DIV_ITER);

   div_state_t       state;
   div_state_t       state_nxt;
   logic [DIV_W-1:0] d;
   logic [DIV_W-1:0] q;
   // The partial remainder's top bit is always zero after a step, so only 16 bits are kept.
   logic [DIV_W-1:0] r;
   logic [CNT_W-1:0] cnt;
   logic             dbz;
   logic [DIV_W:0]   s;
   logic [DIV_W:0]   t;
   logic             cnt_last;
   logic             zero_div;

   assign s        = {r, q[DIV_W-1]};
   assign cnt_last = (cnt == CNT_W'(DIV_ITER - 1));
   assign zero_div = (divisor == '0);

   cla_sub_17 u_sub (
      .a    (s),
      .b    ({1'b0, d}),
      .diff (t)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = zero_div ? DONE : RUN;
         RUN:  if (cnt_last) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         d     <= '0;
         q     <= '0;
         r     <= '0;
         cnt   <= '0;
         dbz   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  d   <= divisor;
                  cnt <= '0;
                  dbz <= zero_div;
                  if (zero_div) begin
                     q <= '1;
                     r <= dividend;
                  end else begin
                     q <= dividend;
                     r <= '0;
                  end
               end
            end
            RUN: begin
               // t[16] set means S < D: restore by keeping S.
               r   <= t[DIV_W] ? s[DIV_W-1:0] : t[DIV_W-1:0];
               q   <= {q[DIV_W-2:0], ~t[DIV_W]};
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign quotient    = q;
   assign remainder   = r;
   assign div_by_zero = dbz;

endmodule
